// File: rtl/shift_left_pipe.sv
// Pipelined logical left barrel shifter: stage k applies a shift of 2^k when
// bit k of the amount is set, and tracks whether nonzero bits left through the MSB.
module shift_left_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost,
  output logic             busy
);

  // Unconsumed shift bits of every stage, packed triangularly: stage k keeps SHW-1-k bits.
  localparam int unsigned REM_W = SHW * (SHW - 1) / 2;

  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   lost_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [REM_W-1:0] rem_q;
  logic             advance;

  // Single global stall: the whole pipe moves only when the last stage can drain.
  assign advance   = out_ready | ~valid_q[SHW-1];
  assign in_ready  = advance;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_lost  = lost_q[SHW-1];
  assign busy      = |valid_q;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned STEP    = 32'd1 << k;
    localparam int unsigned NIN     = SHW - k;
    localparam int unsigned OFF_OUT = k * (2 * SHW - 1 - k) / 2;

    logic [NIN-1:0]   sh_in;
    logic [WIDTH-1:0] din;
    logic             lin;
    logic             vin;
    logic [WIDTH-1:0] data_d;
    logic             lost_d;

    if (k == 0) begin : g_src
      assign sh_in = in_shift;
      assign din   = in_data;
      assign lin   = 1'b0;
      assign vin   = in_valid;
    end else begin : g_src
      localparam int unsigned OFF_IN = (k - 1) * (2 * SHW - k) / 2;
      assign sh_in = rem_q[OFF_IN +: NIN];
      assign din   = data_q[k-1];
      assign lin   = lost_q[k-1];
      assign vin   = valid_q[k-1];
    end

    // Bits pushed out are exactly the top STEP bits of the incoming word.
    always_comb begin
      data_d = din;
      lost_d = lin;
      if (sh_in[0]) begin
        data_d = din << STEP;
        lost_d = lin | (|din[WIDTH-1 -: STEP]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        lost_q[k]  <= 1'b0;
        data_q[k]  <= '0;
      end else if (advance) begin
        valid_q[k] <= vin;
        lost_q[k]  <= lost_d;
        data_q[k]  <= data_d;
      end
    end

    if (k < SHW - 1) begin : g_rem
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rem_q[OFF_OUT +: NIN-1] <= '0;
        end else if (advance) begin
          rem_q[OFF_OUT +: NIN-1] <= sh_in[NIN-1:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_left_pipe.sv
// Self-checking bench for shift_left_pipe: directed timing scenarios plus a
// randomized run scored against an arithmetic shift model.
module tb_shift_left_pipe;

  localparam int unsigned N_RAND = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_lost;
  logic        busy;

  int          total = 0;
  int          passed = 0;
  logic        checking = 1'b0;
  logic [64:0] exp_q [$];
  logic [64:0] cap;
  int          sent;
  int          cycles;
  bit          pending;

  logic [63:0] b2b_d [6] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
                             64'hA0A0_A0A0_A0A0_A0A0, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h0000_0000_0000_0001, 64'h0000_0000_0000_0F0F};
  logic [5:0]  b2b_s [6] = '{6'd1, 6'd63, 6'd4, 6'd0, 6'd32, 6'd13};
  logic [64:0] b2b_e [6] = '{{1'b1, 64'h0000_0000_0000_0000}, {1'b0, 64'h8000_0000_0000_0000},
                             {1'b1, 64'h0A0A_0A0A_0A0A_0A00}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF},
                             {1'b0, 64'h0000_0001_0000_0000}, {1'b0, 64'h0000_0000_01E1_E000}};

  always #5 clk = ~clk;

  shift_left_pipe #(.WIDTH(64), .SHW(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lost (out_lost),
    .busy     (busy)
  );

  // Reference: {lost, data << s}; lost means any set bit among the top s bits.
  function automatic logic [64:0] model(input logic [63:0] d, input int unsigned s);
    logic [63:0] r;
    logic        lost;
    r    = d << s;
    lost = (s == 0) ? 1'b0 : ((d >> (64 - s)) != 64'd0);
    return {lost, r};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and hold it until the pipe accepts it.
  task automatic send(input logic [63:0] d, input logic [5:0] s);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", 65'(done), 65'(1));
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 65'(exp_q.size()), 65'(0));
  endtask

  function automatic logic [63:0] rand_data();
    case ($urandom_range(0, 4))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'd1 << $urandom_range(0, 63);
      2:       return {32'd0, 32'($urandom)} >> $urandom_range(0, 31);
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  function automatic logic [5:0] rand_shift();
    case ($urandom_range(0, 9))
      0:       return 6'd0;
      1:       return 6'd63;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // Scoreboard: in-order queue of expected results, checked every cycle.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
    end else if (checking) begin
      chk("in_ready", 65'(in_ready), 65'(!out_valid || out_ready));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 65'(out_valid), 65'(0));
        end else begin
          chk("result", {out_lost, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_valid_known", 65'(out_valid), 65'(0));
      end
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in_data, 32'(in_shift)));
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_out_data",  65'(out_data),  65'(0));
    chk("rst_out_lost",  65'(out_lost),  65'(0));
    chk("rst_busy",      65'(busy),      65'(0));
    chk("rst_in_ready",  65'(in_ready),  65'(1));

    chk("pin_lat", model(64'h1, 1), {1'b0, 64'h2});
    for (int j = 0; j < 6; j++) chk("pin_table", model(b2b_d[j], 32'(b2b_s[j])), b2b_e[j]);

    rst_n = 1'b1;
    tick();
    checking = 1'b1;

    // Latency: result appears exactly six edges after the input transfer.
    send(64'h1, 6'd1);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("lat_wait", 65'(out_valid), 65'(0));
      tick();
    end
    @(negedge clk);
    chk("lat_valid", 65'(out_valid), 65'(1));
    chk("lat_data", {out_lost, out_data}, {1'b0, 64'h2});
    tick();
    @(negedge clk);
    chk("lat_gap", 65'(out_valid), 65'(0));
    tick();

    // Back-to-back issue: six results on six consecutive cycles, in order.
    for (int j = 0; j < 6; j++) send(b2b_d[j], b2b_s[j]);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("b2b_valid", 65'(out_valid), 65'(1));
      chk("b2b_data", {out_lost, out_data}, b2b_e[j]);
      tick();
    end
    @(negedge clk);
    chk("b2b_end", 65'(out_valid), 65'(0));
    tick();

    // Backpressure: fill with the sink stalled, hold four cycles, then drain.
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) send(rand_data(), rand_shift());
    @(negedge clk);
    cap = {out_lost, out_data};
    chk("bp_valid", 65'(out_valid), 65'(1));
    chk("bp_busy", 65'(busy), 65'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 65'(out_valid), 65'(1));
      chk("bp_hold_ready", 65'(in_ready), 65'(0));
      chk("bp_hold_data", {out_lost, out_data}, cap);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(20);
    repeat (3) tick();

    // Bubble: valid, idle, valid keeps its one-cycle gap at the output.
    send(64'h1, 6'd4);
    tick();
    send(64'h1, 6'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bub_first", {out_valid, out_data}, {1'b1, 64'h10});
    @(negedge clk);
    chk("bub_gap", 65'(out_valid), 65'(0));
    @(negedge clk);
    chk("bub_second", {out_valid, out_data}, {1'b1, 64'h10});
    tick();
    repeat (3) tick();

    // Reset mid-flight discards everything in the pipe.
    send(64'h3, 6'd2);
    send(64'h5, 6'd7);
    in_valid = 1'b1; in_data = 64'h7; in_shift = 6'd9;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 65'(busy), 65'(0));
    for (int i = 0; i < 10; i++) begin
      chk("rstmid_quiet", 65'(out_valid), 65'(0));
      @(negedge clk);
    end
    tick();

    // Random traffic with random sink stalls, scored by the queue model.
    sent = 0; cycles = 0; pending = 1'b0;
    while (sent < int'(N_RAND) && cycles < 60000) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = rand_data();
          in_shift = rand_shift();
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pending && in_ready === 1'b1) begin
        sent++;
        pending = 1'b0;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", 65'(sent), 65'(N_RAND));
    wait_drain(50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_left_pipe.md
Name: shift_left_pipe

Overview:
- Pipelined 64-bit logical left barrel shifter; the left-direction counterpart to the ALU's combinational arithmetic right shifter.
- Registers one shift-amount bit per stage (log2 decomposition) and accepts one operation per cycle.
- Uses a valid/ready handshake on both ends.
- Also reports whether any nonzero bits were shifted out, which the ALU uses for overflow detection.

Parameters:
- WIDTH, 64, data width in bits.
- SHW, 6, shift-amount width. Must equal log2(WIDTH). Also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  source presents an operation
- in_ready  output  1  pipeline can accept this cycle
- in_data  input  WIDTH  operand
- in_shift  input  SHW  shift amount, unsigned, range 0..WIDTH-1
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_data  output  WIDTH  in_data << in_shift, zero-filled from LSB
- out_lost  output  1  1 if any nonzero bit was shifted past the MSB
- busy  output  1  OR of all stage valid bits

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-low; one clock.
  - While rst_n=0 at a rising edge, all stage valid bits, data, residual shift and lost flags clear to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_lost=0, busy=0, in_ready=1.
- Stage structure:
  - Stage k (k=0..SHW-1) holds: valid_k, data_k, shift_k (the remaining upper shift bits), lost_k.
  - Stage k takes stage k-1's data (stage 0 takes the input). If shift bit k is 1, it stores data << 2^k; otherwise it stores data unchanged.
  - lost_k = lost_(k-1) OR (OR of the top 2^k bits of the incoming data, when bit k is set).
  - Stage SHW-1 drives out_valid, out_data and out_lost directly from its registers. No combinational path from in_data to out_data.
- Flow control:
  - advance = out_ready OR NOT out_valid.
  - in_ready = advance.
  - When advance=1, every stage loads from its predecessor and valid_0 loads in_valid.
  - When advance=0, every stage holds its value, including the data of invalid stages.
  - A transfer occurs at the input when in_valid AND in_ready, and at the output when out_valid AND out_ready.
- Latency and throughput:
  - Latency is exactly SHW=6 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 operation per cycle.
  - Results leave in issue order.
- Bubbles:
  - A cycle with in_valid=0 and advance=1 inserts a bubble (valid=0) that propagates.
  - Bubbles are not collapsed; the global stall keeps the design simple.
- Arithmetic rules:
  - in_shift=0: out_data = in_data, out_lost=0.
  - in_shift=63: out_data = in_data[0] placed at the MSB; out_lost = OR of in_data[63:1].
  - out_lost never depends on the low bits that remain in the result.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_lost must stay stable and in_ready=0.
- Reset mid-operation: all in-flight operations are discarded. out_valid=0 on the cycle after the reset edge, and no stale result may appear later.
- in_valid while in_ready=0 is ignored. The source must hold its data per handshake rules.
- X-safety: data in invalid stages is don't-care, but must not reach out_data while out_valid=1.

Test Plan:
- Reset, then in_data=64'h0000_0000_0000_0001, in_shift=1, out_ready=1 -> exactly 6 cycles later out_valid=1, out_data=64'h2, out_lost=0; out_valid=0 the next cycle.
- Six back-to-back inputs, one per cycle:
  - {8000_0000_0000_0000,1} -> 0, lost=1
  - {1,63} -> 8000_0000_0000_0000, lost=0
  - {A0A0_A0A0_A0A0_A0A0,4} -> 0A0A_0A0A_0A0A_0A00, lost=1
  - {FFFF_FFFF_FFFF_FFFF,0} -> same value, lost=0
  - {1,32} -> 0000_0001_0000_0000, lost=0
  - {0000_0000_0000_0F0F,13} -> 0000_0000_01E1_E000, lost=0
  - Required: results on 6 consecutive cycles, in order.
- Backpressure:
  - Fill the pipe, then drop out_ready for 4 cycles -> in_ready=0, out_data/out_valid held constant.
  - Raise out_ready -> remaining results drain, none lost or duplicated.
- Bubble: valid, idle, valid with in_shift=4 on data 1 -> outputs 10h, gap cycle with out_valid=0, then 10h.
- Reset mid-flight: issue 3 operations, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid stays 0 for the next 10 cycles; busy=0 after the reset edge.
- Random self-check: 10,000 random {data, shift} with random out_ready toggling -> every result matches (data<<shift), and lost matches (data>>(64-shift))!=0 for shift>0 (0 for shift=0).
